fwd_hazard_tracker: RTL and testbench
=====================================

# fwd_hazard_tracker

Parametrised forwarding and load-use hazard unit for the decode/issue boundary of the pipelined core. It keeps its own shift-register record of the last DEPTH issued writers, so the datapath no longer has to route per-stage destination and write-enable signals. For each of NUM_SRC source operands it returns a forwarding select. It raises a stall when the youngest producer is a load whose data is not yet available, and inserts a bubble into its own tracker while stalling.

## Interface
- NUM_SRC, 2, number of source operands compared per issued instruction
- DEPTH, 2, number of tracked in-flight stages (stage 1 = EX, stage 2 = MEM, ...)
- REG_W, 5, register address width
- ZERO_REG, 31, register index that is never forwarded (XZR)
- LOAD_LAT, 2, lowest stage index whose load result can be forwarded; must satisfy 1..DEPTH
- clk  in  1  core clock
- reset  in  1  asynchronous, active-high reset
- issue_valid  in  1  decode holds a valid instruction this cycle
- issue_rd  in  REG_W  destination of the decoding instruction
- issue_regwrite  in  1  decoding instruction writes issue_rd
- issue_is_load  in  1  decoding instruction is a load
- src_addr  in  NUM_SRC*REG_W  source register addresses; source i occupies bits [i*REG_W +: REG_W]
- src_used  in  NUM_SRC  source i is actually read by the decoding instruction
- flush  in  1  squash all tracked instructions (branch redirect)
- fwd_sel  out  NUM_SRC*SEL_W  per-source select, where SEL_W = $clog2(DEPTH+1)
  - 0 = register file
  - k = forward from stage k
- stall  out  1  hold decode this cycle

## Operation
- Tracker: DEPTH entries, each holding {valid, regwrite, is_load, rd}. Entry k is the instruction currently in stage k.
- Match rule: entry k matches source i when all of the following hold:
  - entry k is valid and has regwrite set
  - rd != ZERO_REG
  - rd == src_addr[i]
- fwd_sel[i] is the smallest matching k, so the youngest producer wins. If nothing matches, or src_used[i] = 0, fwd_sel[i] is 0.
- Load-use rule: stall = 1 if any used source i has its youngest match k with is_load = 1 and k < LOAD_LAT.
  - The source is never forwarded past a stalling match to an older stage.
- fwd_sel values remain driven during a stall but are don't-care for the datapath.
- With the defaults, the encoding matches the existing convention: 00 = RF, 01 = EX, 10 = MEM.
- Update on each rising clk edge:
  - If flush: all entries are cleared to invalid.
  - Otherwise entry k+1 <= entry k for k = 1..DEPTH-1, and entry DEPTH is discarded, because it has written the register file (write-through RF).
  - Entry 1 <= {1, issue_regwrite, issue_is_load, issue_rd} when issue_valid && !stall; otherwise a bubble (valid = 0).
- flush and issue in the same cycle: flush wins and entry 1 becomes a bubble.
- flush does not mask stall combinationally. The stall clears on the next cycle because the tracker is empty.

## Timing
- fwd_sel and stall are combinational from the tracker registers and the current inputs, with zero-cycle latency.
- The tracker advances exactly one stage per clk, independent of stall. Older instructions keep flowing and only a bubble is injected.
- A load at stage 1 stalls a dependent instruction for LOAD_LAT-1 cycles. After that, the instruction issues with fwd_sel = LOAD_LAT.
- Reset (async assert, any time, including mid-stall): all entries become invalid immediately, so stall = 0 and fwd_sel = 0 for every source given any inputs. Deassertion is synchronised externally.
- Statistics counters (when compiled in) reset to 0.

## Configuration
- FWD_STATS_EN defined: adds two outputs, each 32 bits and saturating at all ones, both reset to 0.
  - stall_cycles counts cycles with stall = 1.
  - fwd_events counts cycles in which any fwd_sel is non-zero while stall = 0.
- FWD_STATS_EN undefined: neither port nor the counter logic exists, and the behaviour is otherwise identical.

## Structure
- Package fwd_pkg holds:
  - the tracker entry struct (valid, regwrite, is_load, rd)
  - the ZERO_REG default
  - FWD_RF = 0 as the select encoding constant
- Sub-module fwd_match is instantiated NUM_SRC times. It takes one source address and the tracker array, and produces that source's select plus its load-use flag.
- The top-level module holds:
  - the shift register
  - the stall OR-reduction
  - the optional counters

## Test plan
- Reset, then issue ADD X1 (regwrite); the next cycle, issue a reader of X1 -> fwd_sel[0] = 1, stall = 0. One cycle later, a reader of X1 gets fwd_sel = 2; after that it gets 0.
- Writers to X3 sit in stage 1 and stage 2, and both sources read X3 -> fwd_sel = 1 for both (youngest wins).
- Issue a writer of X31, then a reader of X31 -> fwd_sel = 0.
- Issue a load into X5, then a reader of X5 -> stall = 1 for exactly 1 cycle. Next cycle stall = 0, fwd_sel = 2, and stage 1 holds a bubble.
- Load X5 in stage 1 while a dependent instruction is in decode, with flush = 1 in the same cycle -> stall = 1 in that cycle. Next cycle the tracker is empty, stall = 0, fwd_sel = 0.
- Assert reset asynchronously mid-stall -> stall = 0 before the next clk edge. With FWD_STATS_EN, stall_cycles = 0.

Source files
------------

// File: rtl/fwd_pkg.sv
// Shared types and constants for the forwarding / load-use hazard tracker.
package fwd_pkg;

  localparam int RD_W_MAX     = 16;
  localparam int ZERO_REG_DEF = 31;
  localparam int FWD_RF       = 0;

  // rd is sized for the widest supported register address; narrower
  // configurations zero-extend into it.
  typedef struct packed {
    logic                valid;
    logic                regwrite;
    logic                is_load;
    logic [RD_W_MAX-1:0] rd;
  } fwd_entry_t;

endpackage

// File: rtl/fwd_match.sv
// Per-source comparator: picks the youngest matching in-flight writer and
// flags a load whose result is not yet forwardable.
module fwd_match
  import fwd_pkg::*;
#(
  parameter int DEPTH    = 2,
  parameter int REG_W    = 5,
  parameter int ZERO_REG = ZERO_REG_DEF,
  parameter int LOAD_LAT = 2,
  parameter int SEL_W    = $clog2(DEPTH + 1)
) (
  input  logic [REG_W-1:0] src_addr,
  input  logic             src_used,
  input  fwd_entry_t       entries [DEPTH],
  output logic [SEL_W-1:0] sel,
  output logic             load_use
);

  logic [RD_W_MAX-1:0] src_ext;
  logic [RD_W_MAX-1:0] zero_ext;
  logic                found;

  assign src_ext  = RD_W_MAX'(src_addr);
  assign zero_ext = RD_W_MAX'(ZERO_REG);

  // entries[0] is stage 1, so the first hit is the youngest producer.
  always_comb begin
    sel      = SEL_W'(FWD_RF);
    load_use = 1'b0;
    found    = 1'b0;
    for (int k = 0; k < DEPTH; k++) begin
      if (!found && src_used && entries[k].valid && entries[k].regwrite &&
          entries[k].rd != zero_ext && entries[k].rd == src_ext) begin
        found    = 1'b1;
        sel      = SEL_W'(k + 1);
        load_use = entries[k].is_load && ((k + 1) < LOAD_LAT);
      end
    end
  end

endmodule

// File: rtl/fwd_hazard_tracker.sv
// Forwarding select and load-use stall unit with its own in-flight writer record.
// Optional FWD_STATS_EN adds saturating stall_cycles / fwd_events counters.
module fwd_hazard_tracker
  import fwd_pkg::*;
#(
  parameter  int NUM_SRC  = 2,
  parameter  int DEPTH    = 2,
  parameter  int REG_W    = 5,
  parameter  int ZERO_REG = ZERO_REG_DEF,
  parameter  int LOAD_LAT = 2,
  localparam int SEL_W    = $clog2(DEPTH + 1)
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     issue_valid,
  input  logic [REG_W-1:0]         issue_rd,
  input  logic                     issue_regwrite,
  input  logic                     issue_is_load,
  input  logic [NUM_SRC*REG_W-1:0] src_addr,
  input  logic [NUM_SRC-1:0]       src_used,
  input  logic                     flush,
  output logic [NUM_SRC*SEL_W-1:0] fwd_sel,
  output logic                     stall
`ifdef FWD_STATS_EN
  ,
  output logic [31:0]              stall_cycles,
  output logic [31:0]              fwd_events
`endif
);

  fwd_entry_t           trk [DEPTH];
  fwd_entry_t           new_ent;
  logic [NUM_SRC-1:0]   load_use;

  for (genvar i = 0; i < NUM_SRC; i++) begin : g_src
    fwd_match #(
      .DEPTH    (DEPTH),
      .REG_W    (REG_W),
      .ZERO_REG (ZERO_REG),
      .LOAD_LAT (LOAD_LAT),
      .SEL_W    (SEL_W)
    ) u_match (
      .src_addr (src_addr[i*REG_W +: REG_W]),
      .src_used (src_used[i]),
      .entries  (trk),
      .sel      (fwd_sel[i*SEL_W +: SEL_W]),
      .load_use (load_use[i])
    );
  end

  assign stall = |load_use;

  always_comb begin
    new_ent = '0;
    if (issue_valid && !stall) begin
      new_ent.valid    = 1'b1;
      new_ent.regwrite = issue_regwrite;
      new_ent.is_load  = issue_is_load;
      new_ent.rd       = RD_W_MAX'(issue_rd);
    end
  end

  // The tracker always advances; a stall only turns the new stage-1 entry into a bubble.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int k = 0; k < DEPTH; k++) trk[k] <= '0;
    end else if (flush) begin
      for (int k = 0; k < DEPTH; k++) trk[k] <= '0;
    end else begin
      trk[0] <= new_ent;
      for (int k = 1; k < DEPTH; k++) trk[k] <= trk[k-1];
    end
  end

`ifdef FWD_STATS_EN
  logic fwd_any;
  assign fwd_any = |fwd_sel;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_cycles <= '0;
      fwd_events   <= '0;
    end else begin
      if (stall && stall_cycles != '1) stall_cycles <= stall_cycles + 32'd1;
      if (!stall && fwd_any && fwd_events != '1) fwd_events <= fwd_events + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_fwd_hazard_tracker.sv
// Self-checking bench for fwd_hazard_tracker: directed pipeline scenarios plus
// randomized traffic against a queue-based model of the in-flight instructions.
module tb_fwd_hazard_tracker;

  localparam int NUM_SRC  = 2;
  localparam int DEPTH    = 2;
  localparam int REG_W    = 5;
  localparam int LOAD_LAT = 2;
  localparam int SEL_W    = 2;
  localparam int ZR       = 31;

  logic                     clk = 1'b0;
  logic                     reset;
  logic                     issue_valid;
  logic [REG_W-1:0]         issue_rd;
  logic                     issue_regwrite;
  logic                     issue_is_load;
  logic [NUM_SRC*REG_W-1:0] src_addr;
  logic [NUM_SRC-1:0]       src_used;
  logic                     flush;
  logic [NUM_SRC*SEL_W-1:0] fwd_sel;
  logic                     stall;
`ifdef FWD_STATS_EN
  logic [31:0]              stall_cycles;
  logic [31:0]              fwd_events;
`endif

  fwd_hazard_tracker dut (
    .clk            (clk),
    .reset          (reset),
    .issue_valid    (issue_valid),
    .issue_rd       (issue_rd),
    .issue_regwrite (issue_regwrite),
    .issue_is_load  (issue_is_load),
    .src_addr       (src_addr),
    .src_used       (src_used),
    .flush          (flush),
    .fwd_sel        (fwd_sel),
    .stall          (stall)
`ifdef FWD_STATS_EN
    ,
    .stall_cycles   (stall_cycles),
    .fwd_events     (fwd_events)
`endif
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Model: queue of in-flight instructions, index 0 = youngest (stage 1).
  typedef struct {
    bit v;
    bit w;
    bit ld;
    int rd;
  } rec_t;

  rec_t        pipe[$];
  int          exp_sel [NUM_SRC];
  bit          exp_stall;
  int unsigned m_sc;
  int unsigned m_fe;

  function automatic void model_clear();
    rec_t b = '{0, 0, 0, 0};
    pipe.delete();
    for (int k = 0; k < DEPTH; k++) pipe.push_back(b);
  endfunction

  function automatic void model_eval();
    exp_stall = 0;
    for (int i = 0; i < NUM_SRC; i++) begin
      exp_sel[i] = 0;
      if (src_used[i]) begin
        for (int k = 0; k < pipe.size(); k++) begin
          if (pipe[k].v && pipe[k].w && pipe[k].rd != ZR &&
              pipe[k].rd == int'(src_addr[i*REG_W +: REG_W])) begin
            exp_sel[i] = k + 1;
            if (pipe[k].ld && (k + 1) < LOAD_LAT) exp_stall = 1;
            break;
          end
        end
      end
    end
  endfunction

  function automatic void model_clock();
    rec_t n = '{0, 0, 0, 0};
    bit any = 0;
    for (int i = 0; i < NUM_SRC; i++) if (exp_sel[i] != 0) any = 1;
    if (exp_stall) m_sc++;
    else if (any) m_fe++;
    if (flush) begin
      model_clear();
    end else begin
      if (issue_valid && !exp_stall)
        n = '{1, issue_regwrite, issue_is_load, int'(issue_rd)};
      pipe.push_front(n);
      void'(pipe.pop_back());
    end
  endfunction

  task automatic check_outputs(input string tag);
    model_eval();
    for (int i = 0; i < NUM_SRC; i++)
      chk($sformatf("%s_sel%0d", tag, i), 32'(fwd_sel[i*SEL_W +: SEL_W]), 32'(exp_sel[i]));
    chk({tag, "_stall"}, 32'(stall), 32'(exp_stall));
`ifdef FWD_STATS_EN
    chk({tag, "_stall_cycles"}, stall_cycles, m_sc);
    chk({tag, "_fwd_events"}, fwd_events, m_fe);
`endif
  endtask

  task automatic apply(input string tag, input bit v, input int rd, input bit rw, input bit ld,
                       input int s0, input int s1, input bit [1:0] used, input bit fl);
    @(negedge clk);
    issue_valid    = v;
    issue_rd       = REG_W'(rd);
    issue_regwrite = rw;
    issue_is_load  = ld;
    src_addr       = {REG_W'(s1), REG_W'(s0)};
    src_used       = used;
    flush          = fl;
    #1;
    check_outputs(tag);
  endtask

  task automatic adv();
    @(posedge clk);
    model_clock();
  endtask

  int regs [4] = '{1, 2, 3, 31};

  initial begin
    reset = 1'b1;
    issue_valid = 0; issue_rd = '0; issue_regwrite = 0; issue_is_load = 0;
    src_addr = '0; src_used = '0; flush = 0;
    m_sc = 0; m_fe = 0;
    model_clear();

    #12;
    issue_valid = 1; issue_rd = 5'd1; issue_regwrite = 1; issue_is_load = 1;
    src_addr = {5'd1, 5'd1}; src_used = 2'b11;
    #1;
    chk("reset_sel", 32'(fwd_sel), 32'd0);
    chk("reset_stall", 32'(stall), 32'd0);
    @(negedge clk);
    reset = 1'b0;

    // ALU forwarding: EX, then MEM, then register file.
    apply("add_x1", 1, 1, 1, 0, 0, 0, 2'b00, 0); adv();
    apply("rd_ex", 1, 2, 1, 0, 1, 0, 2'b01, 0);
    chk("plan_ex_sel", 32'(fwd_sel[1:0]), 32'd1);
    chk("plan_ex_stall", 32'(stall), 32'd0);
    adv();
    apply("rd_mem", 1, 4, 0, 0, 1, 0, 2'b01, 0);
    chk("plan_mem_sel", 32'(fwd_sel[1:0]), 32'd2);
    adv();
    apply("rd_rf", 0, 0, 0, 0, 1, 0, 2'b01, 0);
    chk("plan_rf_sel", 32'(fwd_sel[1:0]), 32'd0);
    adv();

    // Youngest producer wins.
    apply("w3_a", 1, 3, 1, 0, 0, 0, 2'b00, 0); adv();
    apply("w3_b", 1, 3, 1, 0, 0, 0, 2'b00, 0); adv();
    apply("rd_x3", 0, 0, 0, 0, 3, 3, 2'b11, 0);
    chk("plan_young", 32'(fwd_sel), 32'b0101);
    adv();

    // XZR never forwards.
    apply("w31", 1, 31, 1, 0, 0, 0, 2'b00, 0); adv();
    apply("rd_x31", 0, 0, 0, 0, 31, 31, 2'b11, 0);
    chk("plan_xzr", 32'(fwd_sel), 32'd0);
    adv();

    // Load-use: one stall cycle, then forward from MEM with a bubble in EX.
    apply("ld_x5", 1, 5, 1, 1, 0, 0, 2'b00, 0); adv();
    apply("lu_stall", 1, 6, 1, 0, 5, 6, 2'b11, 0);
    chk("plan_lu_stall", 32'(stall), 32'd1);
    adv();
    apply("lu_go", 1, 6, 1, 0, 5, 6, 2'b11, 0);
    chk("plan_lu_go_stall", 32'(stall), 32'd0);
    chk("plan_lu_go_sel", 32'(fwd_sel[1:0]), 32'd2);
    chk("plan_lu_bubble", 32'(fwd_sel[3:2]), 32'd0);
    adv();

    // Flush alongside a load-use: stall still visible, tracker empty afterwards.
    apply("ld_fl", 1, 5, 1, 1, 0, 0, 2'b00, 0); adv();
    apply("fl_stall", 1, 7, 1, 0, 5, 0, 2'b01, 1);
    chk("plan_fl_stall", 32'(stall), 32'd1);
    adv();
    apply("fl_after", 0, 0, 0, 0, 5, 5, 2'b11, 0);
    chk("plan_fl_after_stall", 32'(stall), 32'd0);
    chk("plan_fl_after_sel", 32'(fwd_sel), 32'd0);
    adv();

    // Async reset in the middle of a stall.
    apply("ld_rst", 1, 5, 1, 1, 0, 0, 2'b00, 0); adv();
    apply("rst_pre", 1, 8, 1, 0, 5, 5, 2'b11, 0);
    chk("plan_rst_pre_stall", 32'(stall), 32'd1);
    #2 reset = 1'b1;
    #1;
    chk("plan_rst_stall", 32'(stall), 32'd0);
    chk("plan_rst_sel", 32'(fwd_sel), 32'd0);
    model_clear();
    m_sc = 0; m_fe = 0;
`ifdef FWD_STATS_EN
    chk("plan_rst_stall_cycles", stall_cycles, 32'd0);
`endif
    @(negedge clk);
    reset = 1'b0;

    for (int n = 0; n < 400; n++) begin
      apply("rand", $urandom_range(0, 3) != 0, regs[$urandom_range(0, 3)],
            $urandom_range(0, 1) == 1, $urandom_range(0, 2) == 0,
            regs[$urandom_range(0, 3)], regs[$urandom_range(0, 3)],
            2'($urandom_range(0, 3)), $urandom_range(0, 15) == 0);
      adv();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
